decoder_2to4: RTL and testbench
===============================

Name: decoder_2to4

Overview:
- 2-to-4 one-hot decoder: a 2-bit select drives exactly one of four discrete outputs d0..d3.
- Registered by default so outputs are glitch-free for downstream select/enable fan-out.
- Optional combinational mode, enable gating and output polarity control.
- Sits between a select/address source and four enable lines of peripheral blocks.

Parameters:
- REGISTERED, 1, 1 = outputs registered (1-cycle latency); 0 = outputs combinational from a.
- ACTIVE_LOW, 0, 0 = asserted output is 1; 1 = asserted output is 0 (all outputs inverted).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  decode enable; 0 = no output asserted (comb mode) or hold (registered mode).
- a  input  2  select code.
- d0  output  1  asserted when decoded select == 2'b00.
- d1  output  1  asserted when decoded select == 2'b01.
- d2  output  1  asserted when decoded select == 2'b10.
- d3  output  1  asserted when decoded select == 2'b11.
- valid  output  1  1 when exactly one of d0..d3 is asserted.
- changed  output  1  one-cycle pulse when the asserted output index changes.

Behaviour:
- Decode function: dN asserted iff select == N; at most one output asserted at any time.
- "Asserted" = 1 if ACTIVE_LOW=0, else 0; "deasserted" is the opposite level.
- Reset (rst=1, any time, independent of clk):
  - all d0..d3 deasserted; valid=0; changed=0.
  - internal select register = 2'b00; internal enable flag = 0.
- Reset release: first decode occurs on the first rising clk edge with rst=0.
- REGISTERED=1:
  - on rising clk with rst=0 and en=1, capture a and set enable flag=1.
  - outputs = one-hot of captured select; 1-cycle latency from a to dN.
  - en=0 at an edge: captured select and outputs hold previous value; no outputs deassert.
  - a changing between edges has no effect until the next enabled edge.
- REGISTERED=0:
  - dN = (en && a==N) combinationally; en=0 deasserts all outputs.
  - rst=1 overrides and deasserts all outputs.
  - no clock dependence for d0..d3.
- valid: combinational from d0..d3 (exactly one asserted, polarity-corrected); 0 during reset and whenever all outputs are deasserted.
- changed (both modes):
  - registered 1-cycle pulse on the clk edge after the polarity-corrected one-hot vector differs from its previous sampled value, including a transition from none asserted to one asserted.
  - 0 after reset until the first difference is sampled.
- a containing X/Z: not a supported input; behaviour undefined.

Test Plan:
- Reset: rst=1 with a=2'b11, en=1 -> d0..d3=0, valid=0, changed=0 immediately, no clk edge required; holds while rst=1.
- Sweep (REGISTERED=1, ACTIVE_LOW=0, en=1): a=00,01,10,11 each held 40 time units, repeated 5 times -> after each capture edge d0..d3 = 1000, 0100, 0010, 0001 respectively; valid=1; changed pulses once per code change.
- Hold: REGISTERED=1, a=2'b10 captured, then en=0 and a=2'b01 -> d2 stays 1, d1 stays 0, changed=0.
- Combinational mode (REGISTERED=0): a=2'b01, en=1 -> d1=1 with no clk edge; en=0 -> all outputs 0, valid=0.
- Polarity (ACTIVE_LOW=1): a=2'b11 captured -> d3=0 and d0=d1=d2=1, valid=1; during reset all outputs=1.
- Mid-operation reset: rst asserted between clk edges while d2=1 -> d2 deasserts asynchronously; after release with a=2'b00 and en=1, d0=1 one edge later.

Source files
------------

// File: rtl/decoder_2to4_if.sv
// decoder_2to4_if: select/enable inputs and decoded outputs of the 2-to-4 decoder
interface decoder_2to4_if;
    logic       en;
    logic [1:0] a;
    logic       d0;
    logic       d1;
    logic       d2;
    logic       d3;
    logic       valid;
    logic       changed;
    modport master (output en, a, input d0, d1, d2, d3, valid, changed);
    modport slave  (input en, a, output d0, d1, d2, d3, valid, changed);
endinterface

// File: rtl/decoder_2to4.sv
// decoder_2to4: one-hot 2-to-4 decoder, registered or combinational, with polarity control
module decoder_2to4 #(
    parameter bit REGISTERED = 1'b1,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input logic           clk,
    input logic           rst,
    decoder_2to4_if.slave bus
);
    logic [3:0] hot_q;
    logic [3:0] hot_d;
    logic [3:0] prev_q;
    logic       changed_q;
    logic       changed_d;
    logic [3:0] hot;
    logic [3:0] d_vec;

    // Captured one-hot select: a new code on enabled edges, otherwise hold.
    // Keeping it one-hot in the register makes the outputs glitch-free.
    always_comb begin
        hot_d     = bus.en ? 4'b0001 << bus.a : hot_q;
        hot       = REGISTERED ? hot_q : ((!rst && bus.en) ? 4'b0001 << bus.a : 4'b0000);
        changed_d = hot != prev_q;
        d_vec     = ACTIVE_LOW ? ~hot : hot;
    end

    // State: captured vector, last sampled vector and change pulse; reset clears all asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hot_q     <= 4'b0000;
            prev_q    <= 4'b0000;
            changed_q <= 1'b0;
        end else begin
            hot_q     <= hot_d;
            prev_q    <= hot;
            changed_q <= changed_d;
        end
    end

    assign bus.d0      = d_vec[0];
    assign bus.d1      = d_vec[1];
    assign bus.d2      = d_vec[2];
    assign bus.d3      = d_vec[3];
    assign bus.valid   = (hot != 4'b0000) && ((hot & (hot - 4'd1)) == 4'b0000);
    assign bus.changed = changed_q;
endmodule

// File: tb/tb_decoder_2to4.sv
// tb_decoder_2to4: randomized and directed checks of three decoder configurations against a select-index model
module tb_decoder_2to4;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic [1:0] a   = 2'b00;
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    decoder_2to4_if if_r ();
    decoder_2to4_if if_c ();
    decoder_2to4_if if_l ();
    assign if_r.en = en;
    assign if_r.a  = a;
    assign if_c.en = en;
    assign if_c.a  = a;
    assign if_l.en = en;
    assign if_l.a  = a;

    decoder_2to4 #(.REGISTERED(1'b1), .ACTIVE_LOW(1'b0)) u_reg  (.clk(clk), .rst(rst), .bus(if_r.slave));
    decoder_2to4 #(.REGISTERED(1'b0), .ACTIVE_LOW(1'b0)) u_comb (.clk(clk), .rst(rst), .bus(if_c.slave));
    decoder_2to4 #(.REGISTERED(1'b1), .ACTIVE_LOW(1'b1)) u_low  (.clk(clk), .rst(rst), .bus(if_l.slave));

    // Model: index of the asserted output, -1 meaning none asserted
    int cap_idx = -1;
    int pv_r = -1;
    int pv_c = -1;
    bit ch_r = 1'b0;
    bit ch_c = 1'b0;
    int c_idx;

    always_comb c_idx = (!rst && en) ? int'(a) : -1;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_idx <= -1;
            pv_r <= -1;
            pv_c <= -1;
            ch_r <= 1'b0;
            ch_c <= 1'b0;
        end else begin
            ch_r <= cap_idx != pv_r;
            pv_r <= cap_idx;
            ch_c <= c_idx != pv_c;
            pv_c <= c_idx;
            if (en) cap_idx <= int'(a);
        end
    end

    function automatic logic [3:0] dvec(int idx, bit low);
        logic [3:0] v;
        for (int n = 0; n < 4; n++) v[n] = (idx == n);
        return low ? ~v : v;
    endfunction

    task automatic check(string name, logic [3:0] act, logic [3:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Every cycle: all three instances against the model
    always @(negedge clk) begin
        check("reg_d",       {if_r.d3, if_r.d2, if_r.d1, if_r.d0}, dvec(cap_idx, 1'b0));
        check("reg_valid",   {3'b0, if_r.valid},   {3'b0, cap_idx >= 0});
        check("reg_changed", {3'b0, if_r.changed}, {3'b0, ch_r});
        check("comb_d",       {if_c.d3, if_c.d2, if_c.d1, if_c.d0}, dvec(c_idx, 1'b0));
        check("comb_valid",   {3'b0, if_c.valid},   {3'b0, c_idx >= 0});
        check("comb_changed", {3'b0, if_c.changed}, {3'b0, ch_c});
        check("low_d",       {if_l.d3, if_l.d2, if_l.d1, if_l.d0}, dvec(cap_idx, 1'b1));
        check("low_valid",   {3'b0, if_l.valid},   {3'b0, cap_idx >= 0});
        check("low_changed", {3'b0, if_l.changed}, {3'b0, ch_r});
    end

    logic [3:0] tab [4];

    initial begin
        tab = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        rst = 1'b1;
        en  = 1'b1;
        a   = 2'b11;
        #3;
        check("rst_reg_d",    {if_r.d3, if_r.d2, if_r.d1, if_r.d0}, 4'b0000);
        check("rst_reg_val",  {3'b0, if_r.valid}, 4'b0000);
        check("rst_reg_chg",  {3'b0, if_r.changed}, 4'b0000);
        check("rst_comb_d",   {if_c.d3, if_c.d2, if_c.d1, if_c.d0}, 4'b0000);
        check("rst_low_d",    {if_l.d3, if_l.d2, if_l.d1, if_l.d0}, 4'b1111);
        check("rst_low_val",  {3'b0, if_l.valid}, 4'b0000);
        repeat (3) @(negedge clk);
        #1;
        check("rst_hold_d",   {if_r.d3, if_r.d2, if_r.d1, if_r.d0}, 4'b0000);
        rst = 1'b0;
        // Sweep: each code held for four edges, five rounds
        for (int rep = 0; rep < 5; rep++) begin
            for (int c = 0; c < 4; c++) begin
                a  = 2'(c);
                en = 1'b1;
                @(posedge clk);
                #1;
                check("sweep_d", {if_r.d3, if_r.d2, if_r.d1, if_r.d0}, tab[c]);
                check("sweep_valid", {3'b0, if_r.valid}, 4'b0001);
                @(posedge clk);
                #1;
                check("sweep_changed", {3'b0, if_r.changed}, 4'b0001);
                repeat (3) @(negedge clk);
                #1;
            end
        end
        // Hold: disabled edges keep the captured code
        a  = 2'b10;
        en = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        en = 1'b0;
        a  = 2'b01;
        repeat (3) @(negedge clk);
        #1;
        check("hold_d",       {if_r.d3, if_r.d2, if_r.d1, if_r.d0}, 4'b0100);
        check("hold_changed", {3'b0, if_r.changed}, 4'b0000);
        check("hold_comb_d",  {if_c.d3, if_c.d2, if_c.d1, if_c.d0}, 4'b0000);
        // Combinational mode responds between edges
        a  = 2'b01;
        en = 1'b1;
        #1;
        check("comb_on_d",   {if_c.d3, if_c.d2, if_c.d1, if_c.d0}, 4'b0010);
        check("comb_on_val", {3'b0, if_c.valid}, 4'b0001);
        en = 1'b0;
        #1;
        check("comb_off_d",   {if_c.d3, if_c.d2, if_c.d1, if_c.d0}, 4'b0000);
        check("comb_off_val", {3'b0, if_c.valid}, 4'b0000);
        // Active-low polarity
        @(negedge clk);
        #1;
        a  = 2'b11;
        en = 1'b1;
        @(posedge clk);
        #1;
        check("low_d3",    {if_l.d3, if_l.d2, if_l.d1, if_l.d0}, 4'b0111);
        check("low_valid", {3'b0, if_l.valid}, 4'b0001);
        // Mid-operation asynchronous reset
        @(negedge clk);
        #1;
        a = 2'b10;
        @(posedge clk);
        #1;
        check("mid_pre_d", {if_r.d3, if_r.d2, if_r.d1, if_r.d0}, 4'b0100);
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_d",   {if_r.d3, if_r.d2, if_r.d1, if_r.d0}, 4'b0000);
        check("mid_rst_val", {3'b0, if_r.valid}, 4'b0000);
        check("mid_rst_low", {if_l.d3, if_l.d2, if_l.d1, if_l.d0}, 4'b1111);
        @(negedge clk);
        #1;
        rst = 1'b0;
        a   = 2'b00;
        en  = 1'b1;
        @(posedge clk);
        #1;
        check("mid_post_d", {if_r.d3, if_r.d2, if_r.d1, if_r.d0}, 4'b0001);
        // Randomized traffic with occasional reset pulses between edges
        repeat (400) begin
            @(negedge clk);
            #1;
            a  = 2'($urandom_range(3));
            en = ($urandom_range(3) != 0);
            if ($urandom_range(29) == 0) begin
                #1 rst = 1'b1;
                #2 rst = 1'b0;
            end
        end
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
